// File: rtl/fp32_maxmin_reduce.sv
// Streaming FP32 max/min reducer: tracks the running extreme of a packet and its index,
// delegating each comparison to an external FP32_cmp and reporting NaN/timeout flags.
module fp32_maxmin_reduce #(
   parameter int unsigned IDX_W       = 8,
   parameter int unsigned CMP_LAT     = 2,
   parameter int unsigned CMP_TIMEOUT = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_mode,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [31:0]      s_data,
   input  logic             s_last,
   output logic             cmp_valid,
   output logic [2:0]       cmp_op,
   output logic [31:0]      cmp_a,
   output logic [31:0]      cmp_b,
   input  logic             cmp_res_valid,
   input  logic             cmp_res,
   input  logic             cmp_nan_err,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [31:0]      m_data,
   output logic [IDX_W-1:0] m_idx,
   output logic             m_nan,
   output logic             m_timeout
);

   localparam int unsigned DW    = 32;
   // Timeout must exceed nominal latency; clamp so a bad override cannot starve results.
   localparam int unsigned TMO   = (CMP_TIMEOUT > CMP_LAT) ? CMP_TIMEOUT : CMP_LAT + 1;
   localparam int unsigned TMR_W = $clog2(TMO + 1);
   localparam logic [2:0]  OP_GT = 3'd1;
   localparam logic [2:0]  OP_LT = 3'd3;

   typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WAIT, S_DONE} state_t;

   state_t             state_q, state_d;
   logic               mode_q, mode_d, mode_eff;
   logic [DW-1:0]      running_q, running_d;
   logic [IDX_W-1:0]   run_idx_q, run_idx_d;
   logic               have_q, have_d;
   logic [IDX_W-1:0]   idx_cnt_q, idx_cnt_d;
   logic [IDX_W-1:0]   pend_idx_q, pend_idx_d;
   logic               pend_last_q, pend_last_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               nan_q, nan_d;
   logic               to_q, to_d;
   logic               s_ready_q, s_ready_d;
   logic               cmp_valid_q, cmp_valid_d;
   logic [2:0]         cmp_op_q, cmp_op_d;
   logic [DW-1:0]      cmp_a_q, cmp_a_d;
   logic [DW-1:0]      cmp_b_q, cmp_b_d;
   logic               m_valid_q, m_valid_d;
   logic [DW-1:0]      m_data_q, m_data_d;
   logic [IDX_W-1:0]   m_idx_q, m_idx_d;
   logic               m_nan_q, m_nan_d;
   logic               m_to_q, m_to_d;
   logic               beat, in_nan, resolve;

   assign beat   = s_valid && s_ready_q;
   assign in_nan = (s_data[30:23] == 8'hFF) && (s_data[22:0] != 23'd0);

   // Next-state and output logic
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      mode_eff    = (state_q == S_IDLE) ? i_mode : mode_q;
      running_d   = running_q;
      run_idx_d   = run_idx_q;
      have_d      = have_q;
      idx_cnt_d   = idx_cnt_q;
      pend_idx_d  = pend_idx_q;
      pend_last_d = pend_last_q;
      timer_d     = timer_q;
      nan_d       = nan_q;
      to_d        = to_q;
      cmp_valid_d = 1'b0;
      cmp_op_d    = cmp_op_q;
      cmp_a_d     = cmp_a_q;
      cmp_b_d     = cmp_b_q;
      resolve     = 1'b0;

      case (state_q)
         S_IDLE, S_ACCEPT: begin
            if (beat) begin
               mode_d    = mode_eff;
               idx_cnt_d = idx_cnt_q + 1'b1;
               state_d   = S_ACCEPT;
               if (!have_q) begin
                  // First usable element seeds the running value without a compare.
                  if (in_nan) begin
                     nan_d = 1'b1;
                  end else begin
                     running_d = s_data;
                     run_idx_d = idx_cnt_q;
                     have_d    = 1'b1;
                  end
                  if (s_last) state_d = S_DONE;
               end else begin
                  cmp_valid_d = 1'b1;
                  cmp_a_d     = s_data;
                  cmp_b_d     = running_q;
                  cmp_op_d    = mode_eff ? OP_LT : OP_GT;
                  pend_idx_d  = idx_cnt_q;
                  pend_last_d = s_last;
                  timer_d     = '0;
                  state_d     = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            timer_d = timer_q + 1'b1;
            if (cmp_res_valid) begin
               resolve = 1'b1;
               if (cmp_nan_err) begin
                  nan_d = 1'b1;
               end else if (cmp_res) begin
                  running_d = cmp_a_q;
                  run_idx_d = pend_idx_q;
               end
            end else if (timer_q == TMR_W'(TMO)) begin
               resolve = 1'b1;
               to_d    = 1'b1;
            end
            if (resolve) state_d = pend_last_q ? S_DONE : S_ACCEPT;
         end
         S_DONE: begin
            if (m_valid_q && m_ready) begin
               state_d     = S_IDLE;
               running_d   = '0;
               run_idx_d   = '0;
               have_d      = 1'b0;
               idx_cnt_d   = '0;
               pend_idx_d  = '0;
               pend_last_d = 1'b0;
               nan_d       = 1'b0;
               to_d        = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      s_ready_d = (state_d == S_IDLE) || (state_d == S_ACCEPT);
      m_valid_d = (state_d == S_DONE);
      m_data_d  = m_valid_d ? (have_d ? running_d : 32'hFFFF_FFFF) : '0;
      m_idx_d   = (m_valid_d && have_d) ? run_idx_d : '0;
      m_nan_d   = m_valid_d && nan_d;
      m_to_d    = m_valid_d && to_d;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         mode_q      <= 1'b0;
         running_q   <= '0;
         run_idx_q   <= '0;
         have_q      <= 1'b0;
         idx_cnt_q   <= '0;
         pend_idx_q  <= '0;
         pend_last_q <= 1'b0;
         timer_q     <= '0;
         nan_q       <= 1'b0;
         to_q        <= 1'b0;
         s_ready_q   <= 1'b0;
         cmp_valid_q <= 1'b0;
         cmp_op_q    <= '0;
         cmp_a_q     <= '0;
         cmp_b_q     <= '0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         m_idx_q     <= '0;
         m_nan_q     <= 1'b0;
         m_to_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         running_q   <= running_d;
         run_idx_q   <= run_idx_d;
         have_q      <= have_d;
         idx_cnt_q   <= idx_cnt_d;
         pend_idx_q  <= pend_idx_d;
         pend_last_q <= pend_last_d;
         timer_q     <= timer_d;
         nan_q       <= nan_d;
         to_q        <= to_d;
         s_ready_q   <= s_ready_d;
         cmp_valid_q <= cmp_valid_d;
         cmp_op_q    <= cmp_op_d;
         cmp_a_q     <= cmp_a_d;
         cmp_b_q     <= cmp_b_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         m_idx_q     <= m_idx_d;
         m_nan_q     <= m_nan_d;
         m_to_q      <= m_to_d;
      end
   end

   assign s_ready   = s_ready_q;
   assign cmp_valid = cmp_valid_q;
   assign cmp_op    = cmp_op_q;
   assign cmp_a     = cmp_a_q;
   assign cmp_b     = cmp_b_q;
   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;
   assign m_idx     = m_idx_q;
   assign m_nan     = m_nan_q;
   assign m_timeout = m_to_q;

endmodule

// File: tb/tb_fp32_maxmin_reduce.sv
// Bench for fp32_maxmin_reduce: behavioural FP32 comparator with droppable results,
// table-driven packets plus hold, reset-in-WAIT and index-wrap sequences.
module tb_fp32_maxmin_reduce;
   localparam int unsigned IDX_W       = 8;
   localparam int unsigned CMP_LAT     = 2;
   localparam int unsigned CMP_TIMEOUT = 8;

   logic             clk, rstn, i_mode, s_valid, s_ready, s_last;
   logic [31:0]      s_data, cmp_a, cmp_b, m_data;
   logic             cmp_valid, cmp_res_valid, cmp_res, cmp_nan_err;
   logic [2:0]       cmp_op;
   logic             m_valid, m_ready, m_nan, m_timeout;
   logic [IDX_W-1:0] m_idx;

   fp32_maxmin_reduce #(.IDX_W(IDX_W), .CMP_LAT(CMP_LAT), .CMP_TIMEOUT(CMP_TIMEOUT)) dut (
      .clk(clk), .rstn(rstn), .i_mode(i_mode), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last), .cmp_valid(cmp_valid), .cmp_op(cmp_op),
      .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_res_valid(cmp_res_valid), .cmp_res(cmp_res),
      .cmp_nan_err(cmp_nan_err), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_idx(m_idx), .m_nan(m_nan), .m_timeout(m_timeout));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Comparator model: total order on FP32 bit patterns, fixed latency, optional drop.
   function automatic logic [31:0] fkey(input logic [31:0] x);
      return x[31] ? ~x : (x | 32'h8000_0000);
   endfunction
   function automatic logic fnan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   logic [CMP_LAT-1:0] pv = '0, pr = '0, pn = '0;
   int               total_cmp = 0;
   int               drop_at = 0;
   logic [2:0]       last_op = '0;

   always @(posedge clk) begin
      pv <= {pv[CMP_LAT-2:0], cmp_valid && ((total_cmp + 1) != drop_at)};
      pr <= {pr[CMP_LAT-2:0], (cmp_op == 3'd3) ? (fkey(cmp_a) < fkey(cmp_b))
                                               : (fkey(cmp_a) > fkey(cmp_b))};
      pn <= {pn[CMP_LAT-2:0], fnan(cmp_a) || fnan(cmp_b)};
      if (cmp_valid) begin
         total_cmp <= total_cmp + 1;
         last_op   <= cmp_op;
      end
   end
   assign cmp_res_valid = pv[CMP_LAT-1];
   assign cmp_res       = pr[CMP_LAT-1];
   assign cmp_nan_err   = pn[CMP_LAT-1];

   typedef struct {
      logic             mode;
      int               n;
      logic [3:0][31:0] e;
      int               drop;
      logic [31:0]      xd;
      logic [IDX_W-1:0] xi;
      logic             xn;
      logic             xt;
      int               ncmp;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   // Called at a negedge; returns at the negedge after the element is accepted.
   task automatic send_elem(input logic [31:0] d, input logic last, input logic mode);
      int g;
      g = 0;
      s_valid = 1'b1; s_data = d; s_last = last; i_mode = mode;
      while (!s_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (g >= 100) bound_fail("s_ready_wait");
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int g;
      g = 0;
      while (!m_valid && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (g >= 200) bound_fail(name);
   endtask

   task automatic handshake();
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
   endtask

   function automatic vec_t mk(input logic mode, input int n, input logic [31:0] e0,
                               input logic [31:0] e1, input logic [31:0] e2,
                               input logic [31:0] e3, input int drop, input logic [31:0] xd,
                               input logic [IDX_W-1:0] xi, input logic xn, input logic xt,
                               input int ncmp);
      vec_t v;
      v.mode = mode; v.n = n; v.drop = drop;
      v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
      v.xd = xd; v.xi = xi; v.xn = xn; v.xt = xt; v.ncmp = ncmp;
      return v;
   endfunction

   vec_t tbl[8];

   initial begin
      int base;
      tbl[0] = mk(0, 4, 32'h3F800000, 32'h40600000, 32'hC0000000, 32'h40600000, 0,
                  32'h40600000, 8'd1, 0, 0, 3);
      tbl[1] = mk(1, 4, 32'h40000000, 32'hBF000000, 32'h7FC00000, 32'hBF000000, 0,
                  32'hBF000000, 8'd1, 1, 0, 3);
      tbl[2] = mk(0, 2, 32'h7FC00001, 32'hFFC00000, 0, 0, 0,
                  32'hFFFFFFFF, 8'd0, 1, 0, 0);
      tbl[3] = mk(0, 3, 32'h3F800000, 32'h40A00000, 32'h40000000, 0, 1,
                  32'h40000000, 8'd2, 0, 1, 2);
      tbl[4] = mk(1, 2, 32'h00000000, 32'h80000000, 0, 0, 0,
                  32'h80000000, 8'd1, 0, 0, 1);
      tbl[5] = mk(0, 3, 32'hC0400000, 32'hBF800000, 32'hC0000000, 0, 0,
                  32'hBF800000, 8'd1, 0, 0, 2);
      tbl[6] = mk(0, 1, 32'h40E00000, 0, 0, 0, 0,
                  32'h40E00000, 8'd0, 0, 0, 0);
      tbl[7] = mk(1, 3, 32'h7F800001, 32'h7F800000, 32'h3F800000, 0, 0,
                  32'h3F800000, 8'd2, 1, 0, 1);

      rstn = 1'b0; i_mode = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
      chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_cmp_valid", {31'd0, cmp_valid}, 32'd0);
      chk("rst_m_data", m_data, 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      chk("idle_s_ready", {31'd0, s_ready}, 32'd1);

      // Table packets; i_mode is flipped after the first beat and must be ignored.
      for (int i = 0; i < 8; i++) begin
         base    = total_cmp;
         drop_at = (tbl[i].drop > 0) ? base + tbl[i].drop : 0;
         for (int k = 0; k < tbl[i].n; k++)
            send_elem(tbl[i].e[k], k == tbl[i].n - 1, (k == 0) ? tbl[i].mode : ~tbl[i].mode);
         wait_done($sformatf("v%0d_done", i));
         chk($sformatf("v%0d_data", i), m_data, tbl[i].xd);
         chk($sformatf("v%0d_idx", i), 32'(m_idx), 32'(tbl[i].xi));
         chk($sformatf("v%0d_nan", i), {31'd0, m_nan}, {31'd0, tbl[i].xn});
         chk($sformatf("v%0d_timeout", i), {31'd0, m_timeout}, {31'd0, tbl[i].xt});
         chk($sformatf("v%0d_ncmp", i), 32'(total_cmp - base), 32'(tbl[i].ncmp));
         if (tbl[i].ncmp > 0)
            chk($sformatf("v%0d_op", i), 32'(last_op), tbl[i].mode ? 32'd3 : 32'd1);
         chk($sformatf("v%0d_done_s_ready", i), {31'd0, s_ready}, 32'd0);
         handshake();
         chk($sformatf("v%0d_post_m_valid", i), {31'd0, m_valid}, 32'd0);
         drop_at = 0;
      end

      // Back-pressure in DONE: outputs hold, input stays closed.
      for (int k = 0; k < 4; k++) send_elem(tbl[0].e[k], k == 3, 1'b0);
      wait_done("hold_done");
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("hold%0d_m_valid", c), {31'd0, m_valid}, 32'd1);
         chk($sformatf("hold%0d_m_data", c), m_data, 32'h40600000);
         chk($sformatf("hold%0d_m_idx", c), 32'(m_idx), 32'd1);
         chk($sformatf("hold%0d_s_ready", c), {31'd0, s_ready}, 32'd0);
         @(negedge clk);
      end
      handshake();
      chk("hold_post_m_valid", {31'd0, m_valid}, 32'd0);
      chk("hold_post_s_ready", {31'd0, s_ready}, 32'd1);

      // Asynchronous reset while a compare is outstanding.
      send_elem(32'h3F800000, 1'b0, 1'b0);
      send_elem(32'h40000000, 1'b0, 1'b0);
      chk("rstw_cmp_valid_pre", {31'd0, cmp_valid}, 32'd1);
      rstn = 1'b0;
      #1;
      chk("rstw_s_ready", {31'd0, s_ready}, 32'd0);
      chk("rstw_cmp_valid", {31'd0, cmp_valid}, 32'd0);
      chk("rstw_cmp_a", cmp_a, 32'd0);
      chk("rstw_cmp_b", cmp_b, 32'd0);
      chk("rstw_cmp_op", 32'(cmp_op), 32'd0);
      chk("rstw_m_flags", {28'd0, m_valid, m_nan, m_timeout, |m_idx}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("rstw_idle_s_ready", {31'd0, s_ready}, 32'd1);
      repeat (4) @(negedge clk);
      chk("rstw_stray_m_valid", {31'd0, m_valid}, 32'd0);
      send_elem(32'h40E00000, 1'b1, 1'b0);
      wait_done("rstw_next_done");
      chk("rstw_next_data", m_data, 32'h40E00000);
      chk("rstw_next_idx", 32'(m_idx), 32'd0);
      handshake();

      // Long packet: index counter wraps modulo 2^IDX_W.
      base = total_cmp;
      for (int i = 0; i < 300; i++)
         send_elem((i == 260) ? 32'h42C80000 : 32'h3F800000, i == 299, 1'b0);
      wait_done("wrap_done");
      chk("wrap_data", m_data, 32'h42C80000);
      chk("wrap_idx", 32'(m_idx), 32'd4);
      chk("wrap_flags", {30'd0, m_nan, m_timeout}, 32'd0);
      chk("wrap_ncmp", 32'(total_cmp - base), 32'd299);
      handshake();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
